snake_game_controller: RTL and testbench
========================================

# snake_game_controller

Top-level sequencer for the snake game's score path and movement timing. Sits between the collision detectors and the decimal score counter. Issues one-cycle score-increment and score-clear commands, and tracks the game phase (idle / playing / won / lost). Generates the snake movement tick, whose period shortens as the score rises.

## Interface
Parameters:
- WIN_SCORE, 10: score at which the game is won; the score counter saturates at this value.
- TICK_BASE, 24'd5_000_000: movement period in cycles at score 0.
- TICK_STEP, 24'd400_000: period reduction per score point.
- TICK_MIN, 24'd1_000_000: floor on the movement period.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  debounced, synchronous start button level.
- TARGET_HIT  in  1  level from the head/target comparator; may stay high for many cycles.
- SNAKE_COLLISION  in  1  level; head hit wall or body.
- CURRENT_SCORE  in  4  value fed back from the score counter.
- SCORE_RESET  out  1  clears the score counter; high throughout IDLE.
- REACHED_TARGET  out  1  one-cycle increment pulse to the score counter.
- NEW_TARGET  out  1  one-cycle pulse asking the target generator to relocate; coincident with REACHED_TARGET.
- MOVE_TICK  out  1  one-cycle pulse that advances the snake by one cell.
- GAME_STATE  out  2  0=IDLE, 1=PLAY, 2=WON, 3=LOST.

## Operation
- Edge detection:
  - START_prev and HIT_prev registers, both reset to 0.
  - start_rise = START & ~START_prev; hit_rise = TARGET_HIT & ~HIT_prev.
  - If START is high at reset release, that counts as a rise.
- FSM, encoded as the GAME_STATE values:
  - IDLE: start_rise → PLAY; otherwise stay.
  - PLAY, priority order:
    1. SNAKE_COLLISION=1 → LOST.
    2. CURRENT_SCORE ≥ WIN_SCORE → WON.
    3. Otherwise stay.
  - WON / LOST: start_rise → IDLE. A second START press is needed to replay.
- Increment rule:
  - REACHED_TARGET and NEW_TARGET assert for 1 cycle when all of the following hold: state==PLAY, hit_rise, SNAKE_COLLISION=0, CURRENT_SCORE < WIN_SCORE, REACHED_TARGET currently low.
  - If collision and hit occur in the same cycle, the collision wins: no increment.
  - Holding TARGET_HIT high produces exactly one pulse.
- Movement tick:
  - 24-bit counter cnt.
  - period = max(TICK_MIN, TICK_BASE − CURRENT_SCORE·TICK_STEP), computed at 24 bits; the product is never allowed to underflow.
  - In PLAY: if cnt ≥ period−1, MOVE_TICK=1 and cnt=0; else cnt+1.
  - Using ≥ covers the case where a score increase shrinks the period below the current count.
  - Outside PLAY, cnt=0 and MOVE_TICK=0.
- SCORE_RESET = (state==IDLE), driven directly from the state register, so it is glitch-free.

## Timing
- Reset values:
  - GAME_STATE=IDLE, SCORE_RESET=1.
  - REACHED_TARGET=0, NEW_TARGET=0, MOVE_TICK=0.
  - cnt=0, START_prev=0, HIT_prev=0.
- All outputs are registered. A condition sampled at edge k appears on the outputs after edge k.
- Increment to win:
  - Hit sampled at edge k: pulse high during cycle k..k+1.
  - Score counter increments at edge k+1.
  - If the new score equals WIN_SCORE, state becomes WON at edge k+2.
  - Minimum spacing between pulses is 2 cycles.
- First MOVE_TICK arrives `period` cycles after the edge that enters PLAY.
- Leaving PLAY clears cnt and MOVE_TICK in the same edge. No tick is issued in WON or LOST.
- Asserting RESET mid-game forces IDLE immediately. SCORE_RESET rises asynchronously.

## Structure
- Package snake_pkg holds:
  - the state encoding constants (IDLE/PLAY/WON/LOST);
  - the default WIN_SCORE;
  - the score width (4).
- Sub-module move_tick_divider takes CLK, RESET, enable, a 24-bit period, and outputs a tick. It is reusable for an attract-mode animation.
- Edge detectors stay inline.

## Test plan
- Reset, then START pulse → GAME_STATE 0→1 one cycle after the edge; SCORE_RESET drops. First MOVE_TICK arrives 5_000_000 cycles later (simulate with TICK_BASE=20, TICK_STEP=2, TICK_MIN=8).
- TARGET_HIT held high for 50 cycles in PLAY → exactly one REACHED_TARGET and one NEW_TARGET pulse. Tick period goes 20→18 once CURRENT_SCORE=1.
- 10 separated hits with a model score counter → WON two cycles after the 10th pulse. An 11th hit produces no pulse; MOVE_TICK stops.
- SNAKE_COLLISION and a TARGET_HIT rise in the same cycle → LOST, no REACHED_TARGET. START → IDLE with SCORE_RESET=1; START again → PLAY.
- Score 9 with the small parameters → period = max(8, 20−18) = 8. cnt at 15 when the score increments → MOVE_TICK on the next edge, then 8-cycle spacing.
- RESET asserted mid-PLAY between clock edges → GAME_STATE=0 and SCORE_RESET=1 without waiting for an edge. START held high through reset release → PLAY on the first edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game controller: game-phase encoding,
// score width and the score-dependent movement period.
package snake_pkg;

   localparam int SCORE_W = 4;
   localparam int TICK_W  = 24;

   localparam logic [SCORE_W-1:0] DEFAULT_WIN_SCORE = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WON  = 2'd2,
      LOST = 2'd3
   } game_state_e;

   // The reduction is formed at full product width so a large score can never wrap
   // the subtraction; anything that would go below zero collapses to the floor.
   function automatic logic [TICK_W-1:0] tickPeriod(
      input logic [SCORE_W-1:0] score,
      input logic [TICK_W-1:0]  base,
      input logic [TICK_W-1:0]  step,
      input logic [TICK_W-1:0]  floorPeriod
   );
      logic [TICK_W+SCORE_W-1:0] reduction;
      logic [TICK_W-1:0]         diff;
      reduction = {{TICK_W{1'b0}}, score} * {{SCORE_W{1'b0}}, step};
      if (reduction >= {{SCORE_W{1'b0}}, base}) begin
         diff = '0;
      end else begin
         diff = base - reduction[TICK_W-1:0];
      end
      return (diff < floorPeriod) ? floorPeriod : diff;
   endfunction

endpackage

// File: rtl/move_tick_divider.sv
// Programmable divider emitting a one-cycle tick every `period` enabled cycles;
// also usable for attract-mode animation timing.
module move_tick_divider #(
   parameter int W = 24
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         enable_i,
   input  logic [W-1:0] period_i,
   output logic         tick_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         tick_q, tick_d;
   logic [W-1:0] lastCount;

   assign lastCount = (period_i == '0) ? '0 : period_i - W'(1);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   // A >= compare lets a period that shrinks below the running count fire at once.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (!enable_i) begin
         cnt_d = '0;
      end else if (cnt_q >= lastCount) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else begin
         cnt_d = cnt_q + W'(1);
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/snake_game_controller.sv
// Game-phase sequencer for the snake game: turns hit/collision levels into score
// commands and drives a movement tick that speeds up as the score rises.
module snake_game_controller
   import snake_pkg::*;
#(
   parameter logic [SCORE_W-1:0] WIN_SCORE = DEFAULT_WIN_SCORE,
   parameter logic [TICK_W-1:0]  TICK_BASE = 24'd5_000_000,
   parameter logic [TICK_W-1:0]  TICK_STEP = 24'd400_000,
   parameter logic [TICK_W-1:0]  TICK_MIN  = 24'd1_000_000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               START,
   input  logic               TARGET_HIT,
   input  logic               SNAKE_COLLISION,
   input  logic [SCORE_W-1:0] CURRENT_SCORE,
   output logic               SCORE_RESET,
   output logic               REACHED_TARGET,
   output logic               NEW_TARGET,
   output logic               MOVE_TICK,
   output logic [1:0]         GAME_STATE
);

   game_state_e       state_q, state_d;
   logic              startPrev_q, hitPrev_q;
   logic              reached_q, reached_d;
   logic              startRise, hitRise;
   logic              tickEnable;
   logic [TICK_W-1:0] period;

   assign startRise = START & ~startPrev_q;
   assign hitRise   = TARGET_HIT & ~hitPrev_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         startPrev_q <= 1'b0;
         hitPrev_q   <= 1'b0;
         reached_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         startPrev_q <= START;
         hitPrev_q   <= TARGET_HIT;
         reached_q   <= reached_d;
      end
   end

   // Collision outranks both winning and scoring, so a simultaneous hit is dropped.
   always_comb begin
      state_d   = state_q;
      reached_d = 1'b0;
      unique case (state_q)
         IDLE: if (startRise) state_d = PLAY;
         PLAY: begin
            if (SNAKE_COLLISION) begin
               state_d = LOST;
            end else if (CURRENT_SCORE >= WIN_SCORE) begin
               state_d = WON;
            end else if (hitRise && !reached_q) begin
               reached_d = 1'b1;
            end
         end
         WON, LOST: if (startRise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counting starts only the edge after PLAY is entered and stops on the leaving edge.
   assign tickEnable = (state_q == PLAY) && (state_d == PLAY);
   assign period     = tickPeriod(CURRENT_SCORE, TICK_BASE, TICK_STEP, TICK_MIN);

   move_tick_divider #(
      .W (TICK_W)
   ) u_moveTick (
      .CLK      (CLK),
      .RESET    (RESET),
      .enable_i (tickEnable),
      .period_i (period),
      .tick_o   (MOVE_TICK)
   );

   assign REACHED_TARGET = reached_q;
   assign NEW_TARGET     = reached_q;
   assign SCORE_RESET    = (state_q == IDLE);
   assign GAME_STATE     = state_q;

endmodule

// File: tb/tb_snake_game_controller.sv
// Directed bench for snake_game_controller with small tick parameters and a
// saturating score-counter model fed back into CURRENT_SCORE.
module tb_snake_game_controller;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic       TARGET_HIT;
   logic       SNAKE_COLLISION;
   logic [3:0] CURRENT_SCORE;
   logic       SCORE_RESET;
   logic       REACHED_TARGET;
   logic       NEW_TARGET;
   logic       MOVE_TICK;
   logic [1:0] GAME_STATE;

   logic [3:0] modelScore;
   logic [3:0] overrideScore;
   logic       overrideEn;

   int checks = 0;
   int errors = 0;

   snake_game_controller #(
      .WIN_SCORE (4'd10),
      .TICK_BASE (24'd20),
      .TICK_STEP (24'd2),
      .TICK_MIN  (24'd8)
   ) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .START           (START),
      .TARGET_HIT      (TARGET_HIT),
      .SNAKE_COLLISION (SNAKE_COLLISION),
      .CURRENT_SCORE   (CURRENT_SCORE),
      .SCORE_RESET     (SCORE_RESET),
      .REACHED_TARGET  (REACHED_TARGET),
      .NEW_TARGET      (NEW_TARGET),
      .MOVE_TICK       (MOVE_TICK),
      .GAME_STATE      (GAME_STATE)
   );

   always #5 CLK = ~CLK;

   // Decimal score counter stand-in: clears while SCORE_RESET, saturates at 10.
   always @(posedge CLK) begin
      if (SCORE_RESET) begin
         modelScore <= 4'd0;
      end else if (REACHED_TARGET && modelScore < 4'd10) begin
         modelScore <= modelScore + 4'd1;
      end
   end

   assign CURRENT_SCORE = overrideEn ? overrideScore : modelScore;

   task automatic applyStimulus(input logic s, input logic h, input logic c);
      START           = s;
      TARGET_HIT      = h;
      SNAKE_COLLISION = c;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic waitTick(output int n);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge CLK);
         #1;
         if (MOVE_TICK) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int pulses;
      int newPulses;
      int ticks;

      RESET           = 1'b1;
      START           = 1'b0;
      TARGET_HIT      = 1'b0;
      SNAKE_COLLISION = 1'b0;
      overrideEn      = 1'b0;
      overrideScore   = 4'd0;

      #3;
      checkOutput("rstState", GAME_STATE, 0);
      checkOutput("rstScoreReset", SCORE_RESET, 1);
      checkOutput("rstReached", REACHED_TARGET, 0);
      checkOutput("rstNewTarget", NEW_TARGET, 0);
      checkOutput("rstMoveTick", MOVE_TICK, 0);

      @(posedge CLK);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      applyStimulus(0, 0, 0);
      checkOutput("idleStays", GAME_STATE, 0);

      applyStimulus(1, 0, 0);
      checkOutput("startToPlay", GAME_STATE, 1);
      checkOutput("playScoreReset", SCORE_RESET, 0);
      START = 1'b0;

      waitTick(n);
      checkOutput("firstTickDelay", n, 20);
      applyStimulus(0, 0, 0);
      checkOutput("tickOneCycle", MOVE_TICK, 0);

      pulses    = 0;
      newPulses = 0;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(0, 1, 0);
         if (REACHED_TARGET === 1'b1) pulses++;
         if (NEW_TARGET === 1'b1) newPulses++;
      end
      applyStimulus(0, 0, 0);
      checkOutput("holdOnePulse", pulses, 1);
      checkOutput("holdOneNewTarget", newPulses, 1);

      waitTick(n);
      waitTick(n);
      checkOutput("periodAtScore1", n, 18);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, 1, 0);
         checkOutput("hitPulse", REACHED_TARGET, 1);
         checkOutput("hitNewTarget", NEW_TARGET, 1);
         applyStimulus(0, 0, 0);
         checkOutput("pulseEnds", REACHED_TARGET, 0);
         checkOutput("stillPlaying", GAME_STATE, 1);
         if (i < 8) applyStimulus(0, 0, 0);
      end
      applyStimulus(0, 0, 0);
      checkOutput("wonAfterTenth", GAME_STATE, 2);
      checkOutput("wonNoTick", MOVE_TICK, 0);

      applyStimulus(0, 1, 0);
      checkOutput("eleventhNoPulse", REACHED_TARGET, 0);
      ticks = 0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(0, 0, 0);
         if (MOVE_TICK !== 1'b0) ticks++;
      end
      checkOutput("wonTicksStopped", ticks, 0);

      applyStimulus(1, 0, 0);
      checkOutput("wonToIdle", GAME_STATE, 0);
      checkOutput("idleScoreReset", SCORE_RESET, 1);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput("replayPlay", GAME_STATE, 1);

      applyStimulus(0, 1, 1);
      checkOutput("collisionLost", GAME_STATE, 3);
      checkOutput("collisionNoPulse", REACHED_TARGET, 0);
      applyStimulus(0, 0, 0);
      checkOutput("collisionNoLatePulse", REACHED_TARGET, 0);
      checkOutput("lostNoTick", MOVE_TICK, 0);

      applyStimulus(1, 0, 0);
      checkOutput("lostToIdle", GAME_STATE, 0);
      checkOutput("lostScoreReset", SCORE_RESET, 1);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput("againPlay", GAME_STATE, 1);

      overrideEn    = 1'b1;
      overrideScore = 4'd0;
      ticks = 0;
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, 0, 0);
         if (MOVE_TICK !== 1'b0) ticks++;
      end
      checkOutput("noTickBefore15", ticks, 0);
      overrideScore = 4'd9;
      applyStimulus(0, 0, 0);
      checkOutput("shrinkTickNow", MOVE_TICK, 1);
      waitTick(n);
      checkOutput("periodAtScore9", n, 8);

      #2;
      RESET = 1'b1;
      #1;
      checkOutput("asyncRstState", GAME_STATE, 0);
      checkOutput("asyncRstScoreReset", SCORE_RESET, 1);
      checkOutput("asyncRstTick", MOVE_TICK, 0);
      START = 1'b1;
      #2;
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput("startHeldThroughReset", GAME_STATE, 1);
      START = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
